// File: rtl/led_show_sequencer.sv
// led_show_sequencer: run-time controller for the LED shifter and clock divider.
// Debounces the start/stop and speed buttons, runs an IDLE/RUN/PAUSE/DONE
// state machine and auto-sequences the shifter through its four modes.
module led_show_sequencer #(
  parameter int STEP_TICKS = 16,
  parameter int LOOPS      = 3,
  parameter int DEB_CYCLES = 50000,
  parameter int LOOP_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              ss,
  input  logic              S,
  input  logic              auto_en,
  input  logic [1:0]        mode_man,
  output logic [1:0]        mode,
  output logic              shift_en,
  output logic              speed_sel,
  output logic              running,
  output logic              done,
  output logic [LOOP_W-1:0] loop_cnt
);

  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  // A loop limit that cannot be represented in loop_cnt can never be reached.
  localparam bit LOOP_LIMITED = (LOOPS != 0) && (LOOPS < (1 << LOOP_W));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit 0 is start/stop, bit 1 is speed.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {S, ss};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             acc_q;
      logic [DEB_W-1:0] cnt_q;
      logic             accept;

      // The level is accepted on the DEB_CYCLES-th consecutive clk it differs.
      assign accept   = (sync2_q != acc_q) && (cnt_q == DEB_W'(DEB_CYCLES - 1));
      assign press[gi] = accept && sync2_q;

      // Two-flop synchroniser followed by a restart-on-bounce debounce counter.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          acc_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          if (sync2_q != acc_q) begin
            if (accept) begin
              acc_q <= sync2_q;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
      end
    end
  endgenerate

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        mode_q, mode_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic              shift_en_q, shift_en_d;
  logic              speed_q, speed_d;
  logic              running_q, done_q;
  logic [LOOP_W-1:0] loop_inc;

  // Saturating pass counter increment.
  assign loop_inc = (loop_q == {LOOP_W{1'b1}}) ? loop_q : loop_q + 1'b1;

  // State register plus registered decodes of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      mode_q     <= 2'd0;
      loop_q     <= '0;
      shift_en_q <= 1'b0;
      speed_q    <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mode_q     <= mode_d;
      loop_q     <= loop_d;
      shift_en_q <= shift_en_d;
      speed_q    <= speed_d;
      running_q  <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  // Next-state logic: button presses, tick handling and mode sequencing.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mode_d     = mode_q;
    loop_d     = loop_q;
    shift_en_d = 1'b0;
    speed_d    = speed_q;

    if (press[1]) begin
      speed_d = ~speed_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (press[0]) begin
          state_d = ST_RUN;
          step_d  = '0;
          loop_d  = '0;
          mode_d  = auto_en ? 2'd0 : mode_man;
        end
      end
      ST_RUN: begin
        if (!auto_en) begin
          mode_d = mode_man;
        end
        if (press[0]) begin
          // A press beats a coincident tick: the tick is dropped.
          state_d = ST_PAUSE;
        end else if (tick) begin
          shift_en_d = 1'b1;
          if (step_q == STEP_W'(STEP_TICKS - 1)) begin
            step_d = '0;
            if (auto_en) begin
              if (mode_q == 2'd3) begin
                mode_d = 2'd0;
                loop_d = loop_inc;
                if (LOOP_LIMITED && (loop_inc == LOOP_W'(LOOPS))) begin
                  state_d    = ST_DONE;
                  shift_en_d = 1'b0;
                end
              end else begin
                mode_d = mode_q + 2'd1;
              end
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (!auto_en) begin
          mode_d = mode_man;
        end
        if (press[0]) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (press[0]) begin
          state_d = ST_IDLE;
          mode_d  = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mode      = mode_q;
  assign shift_en  = shift_en_q;
  assign speed_sel = speed_q;
  assign running   = running_q;
  assign done      = done_q;
  assign loop_cnt  = loop_q;

endmodule

// File: tb/tb_led_show_sequencer.sv
// Bench for led_show_sequencer: expected shift modes are queued when a tick is
// driven and popped when shift_en is seen.
module tb_led_show_sequencer;

  localparam int STEP_TICKS = 4;
  localparam int LOOPS      = 2;
  localparam int DEB_CYCLES = 4;
  localparam int LOOP_W     = 4;
  localparam int RUN_TICKS  = STEP_TICKS * 4 * LOOPS;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tick = 1'b0;
  logic              ss = 1'b0;
  logic              S = 1'b0;
  logic              auto_en = 1'b1;
  logic [1:0]        mode_man = 2'd0;
  logic [1:0]        mode;
  logic              shift_en;
  logic              speed_sel;
  logic              running;
  logic              done;
  logic [LOOP_W-1:0] loop_cnt;

  int n_checks  = 0;
  int n_pass    = 0;
  int shift_cnt = 0;
  int k_acc     = 0;
  int base_cnt  = 0;
  int exp_q[$];

  led_show_sequencer #(
    .STEP_TICKS(STEP_TICKS),
    .LOOPS(LOOPS),
    .DEB_CYCLES(DEB_CYCLES),
    .LOOP_W(LOOP_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .ss(ss),
    .S(S),
    .auto_en(auto_en),
    .mode_man(mode_man),
    .mode(mode),
    .shift_en(shift_en),
    .speed_sel(speed_sel),
    .running(running),
    .done(done),
    .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int want);
    n_checks++;
    if (obs == want) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, want);
  endtask

  // Scoreboard: every shift_en must match a queued expectation.
  always @(negedge clk) begin
    if (reset && shift_en) begin
      shift_cnt++;
      check("shift_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("shift_mode", int'(mode), exp_q.pop_front());
    end
  end

  task automatic pulse_tick(input bit expect_shift, input int want_mode);
    if (expect_shift) exp_q.push_back(want_mode);
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk); #1;
  endtask

  // Tick accepted in auto RUN: tick k uses mode (k/STEP_TICKS)%4, last tick ends the run.
  task automatic auto_tick();
    k_acc++;
    pulse_tick(k_acc < RUN_TICKS, (k_acc / STEP_TICKS) % 4);
  endtask

  task automatic press(input bit speed_btn);
    @(posedge clk); #1;
    if (speed_btn) S = 1'b1; else ss = 1'b1;
    repeat (10) @(posedge clk);
    #1 S = 1'b0; ss = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Start/stop press lands on the same clk as a tick (2 sync + DEB_CYCLES clks).
  task automatic collision_press();
    @(posedge clk); #1 ss = 1'b1;
    repeat (1 + DEB_CYCLES) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    repeat (5) @(posedge clk);
    #1 ss = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mode", int'(mode), 0);
    check("rst_shift_en", int'(shift_en), 0);
    check("rst_speed", int'(speed_sel), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    check("rst_loop", int'(loop_cnt), 0);
    @(posedge clk); #1 reset = 1'b1;

    // Bouncing start button, then a clean hold: exactly one press.
    for (int i = 0; i < 10; i++) begin
      ss = ~ss;
      repeat (2) @(posedge clk);
      #1;
    end
    check("bounce_no_press", int'(running), 0);
    ss = 1'b1;
    repeat (10) @(posedge clk);
    #1 ss = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("deb_running", int'(running), 1);
    check("deb_done", int'(done), 0);
    check("deb_mode", int'(mode), 0);

    // Auto run, pause after tick 5.
    repeat (5) auto_tick();
    check("shift_cnt_5", shift_cnt, 5);
    press(1'b0);
    check("pause_running", int'(running), 0);
    pulse_tick(1'b0, 0);
    check("pause_tick_dropped", shift_cnt, 5);
    press(1'b0);
    check("resume_running", int'(running), 1);
    check("resume_loop", int'(loop_cnt), 0);
    auto_tick();
    check("resume_mode", int'(mode), 1);
    while (k_acc < 10) auto_tick();

    // Press and tick together in RUN.
    collision_press();
    check("coll_running", int'(running), 0);
    check("coll_shift_cnt", shift_cnt, 10);
    press(1'b0);
    check("coll_resume", int'(running), 1);
    while (k_acc < 15) auto_tick();
    check("loop_before_wrap", int'(loop_cnt), 0);
    auto_tick();
    check("loop_after_wrap", int'(loop_cnt), 1);
    check("mode_after_wrap", int'(mode), 0);
    while (k_acc < RUN_TICKS - 1) auto_tick();
    check("not_done_yet", int'(done), 0);
    auto_tick();
    check("done_flag", int'(done), 1);
    check("done_running", int'(running), 0);
    check("done_mode", int'(mode), 0);
    check("done_loop", int'(loop_cnt), LOOPS);
    check("done_shift_cnt", shift_cnt, RUN_TICKS - 1);
    repeat (3) pulse_tick(1'b0, 0);
    check("done_ticks_dropped", shift_cnt, RUN_TICKS - 1);

    // DONE -> IDLE keeps loop_cnt.
    press(1'b0);
    check("idle_done", int'(done), 0);
    check("idle_running", int'(running), 0);
    check("idle_mode", int'(mode), 0);
    check("idle_loop_held", int'(loop_cnt), LOOPS);

    // Speed button toggles only speed_sel.
    press(1'b1);
    check("speed_on", int'(speed_sel), 1);
    check("speed_no_start", int'(running), 0);
    press(1'b1);
    check("speed_off", int'(speed_sel), 0);

    // Manual mode.
    auto_en  = 1'b0;
    mode_man = 2'd2;
    press(1'b0);
    check("man_running", int'(running), 1);
    check("man_start_mode", int'(mode), 2);
    check("man_loop_clear", int'(loop_cnt), 0);
    @(posedge clk); #1 mode_man = 2'd1;
    @(negedge clk);
    check("man_latency_old", int'(mode), 2);
    @(negedge clk);
    check("man_latency_new", int'(mode), 1);
    base_cnt = shift_cnt;
    repeat (40) pulse_tick(1'b1, 1);
    check("man_shift_cnt", shift_cnt - base_cnt, 40);
    check("man_loop_frozen", int'(loop_cnt), 0);
    check("man_mode_held", int'(mode), 1);
    press(1'b1);
    check("man_speed_on", int'(speed_sel), 1);
    check("man_speed_running", int'(running), 1);

    // Back to auto: resumes from mode 1 with step count 0.
    auto_en = 1'b1;
    repeat (3) pulse_tick(1'b1, 1);
    pulse_tick(1'b1, 2);
    check("auto_resume_mode", int'(mode), 2);

    // Reset mid-run with a strobe in flight.
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_shift_en", int'(shift_en), 0);
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_speed", int'(speed_sel), 0);
    check("mid_rst_running", int'(running), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_loop", int'(loop_cnt), 0);
    @(posedge clk); #1 reset = 1'b1;
    base_cnt = shift_cnt;
    pulse_tick(1'b0, 0);
    check("post_rst_idle", int'(running), 0);
    check("post_rst_no_shift", shift_cnt - base_cnt, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
